hazard_ctrl_md: RTL

- Next-generation stall/forward controller for the 5-stage MIPS pipeline (D/E/M/W).
- Keeps Tuse/Tnew stall logic and the D/E/M forwarding muxes.
- Adds MDU support: a multi-cycle mult/div scoreboard with configurable latencies and a one-cycle MDU start pulse.
- Sits beside the datapath; drives stall/flush to the PC, D and E registers, and start to the MDU.

---
 rtl/hazard_ctrl_md_pkg.sv | 92 +++++++++
 rtl/hazard_ctrl_md_instr_class.sv | 60 ++++++
 rtl/hazard_ctrl_md.sv | 131 +++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_md_pkg.sv
// rtl/hazard_ctrl_md_pkg.sv - shared opcodes, field helpers and decoded-instruction type
package hazard_ctrl_md_pkg;

  // primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  // md_op encodings (equal to funct[1:0] of the md_cal instruction)
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // pipeline stage index used to select the Tnew view of a decoder
  localparam int STG_D = 0;
  localparam int STG_E = 1;
  localparam int STG_M = 2;
  localparam int STG_W = 3;

  typedef struct packed {
    logic       cal_r;
    logic       cal_i;
    logic       lui;
    logic       lw;
    logic       sw;
    logic       beq;
    logic       jal;
    logic       jr;
    logic       jalr;
    logic       md_cal;
    logic       md_mv;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       we;
    logic [1:0] tnew;
  } instr_info_t;

  function automatic logic [5:0] f_op(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ir);
    return ir[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ir);
    return ir[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] ir);
    return ir[15:11];
  endfunction

  function automatic logic [5:0] f_func(input logic [31:0] ir);
    return ir[5:0];
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_instr_class.sv
// rtl/hazard_ctrl_md_instr_class.sv - per-stage instruction decoder: class flags, destination, Tnew
module instr_class
  import hazard_ctrl_md_pkg::*;
#(
  parameter int STAGE = STG_E
) (
  input  logic [31:0] ir,
  output instr_info_t info
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       r_type;
  logic       writer;
  logic       unused_shamt;

  assign unused_shamt = ^ir[10:6];

  // decode class flags, then derive destination, write-enable and stage Tnew
  always_comb begin
    op     = f_op(ir);
    fn     = f_func(ir);
    r_type = (op == OP_RTYPE);
    info   = '0;

    info.rs     = f_rs(ir);
    info.rt     = f_rt(ir);
    info.md_cal = r_type && (fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
    info.md_mv  = r_type && (fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO});
    info.cal_r  = r_type && (fn inside {FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                                        FN_XOR, FN_NOR, FN_SLT, FN_SLTU, FN_MFHI, FN_MFLO});
    info.cal_i  = op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI};
    info.lui    = (op == OP_LUI);
    info.lw     = (op == OP_LW);
    info.sw     = (op == OP_SW);
    info.beq    = (op == OP_BEQ);
    info.jal    = (op == OP_JAL);
    info.jr     = r_type && (fn == FN_JR);
    info.jalr   = r_type && (fn == FN_JALR);

    if (info.jal)                    info.dst = 5'd31;
    else if (info.cal_r || info.jalr) info.dst = f_rd(ir);
    else                              info.dst = f_rt(ir);

    // a write to $0 is treated as no write at all, so it neither stalls nor forwards
    writer  = info.cal_r || info.cal_i || info.lui || info.lw || info.jal || info.jalr;
    info.we = writer && (info.dst != 5'd0);

    if (STAGE == STG_M) begin
      info.tnew = info.lw ? 2'd1 : 2'd0;
    end else if (STAGE == STG_W) begin
      info.tnew = 2'd0;
    end else begin
      if (info.lw)                           info.tnew = 2'd2;
      else if (info.cal_r || info.cal_i)     info.tnew = 2'd1;
      else                                   info.tnew = 2'd0;
    end
  end

endmodule

// File: rtl/hazard_ctrl_md.sv
// rtl/hazard_ctrl_md.sv - Tuse/Tnew stall, D/E/M forwarding and MDU busy scoreboard
module hazard_ctrl_md
  import hazard_ctrl_md_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = $clog2(((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       IR_D,
  input  logic [31:0]       IR_E,
  input  logic [31:0]       IR_M,
  input  logic [31:0]       IR_W,
  input  logic [DATA_W-1:0] PC8_E,
  input  logic [DATA_W-1:0] PC8_M,
  input  logic [DATA_W-1:0] EXT_E,
  input  logic [DATA_W-1:0] AO_M,
  input  logic [DATA_W-1:0] WD_W,
  input  logic [DATA_W-1:0] RS_D_in,
  input  logic [DATA_W-1:0] RT_D_in,
  input  logic [DATA_W-1:0] RS_E_in,
  input  logic [DATA_W-1:0] RT_E_in,
  input  logic [DATA_W-1:0] RT_M_in,
  output logic [DATA_W-1:0] RS_D,
  output logic [DATA_W-1:0] RT_D,
  output logic [DATA_W-1:0] RS_E,
  output logic [DATA_W-1:0] RT_E,
  output logic [DATA_W-1:0] RT_M,
  output logic              stall,
  output logic              flush_E,
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic              md_busy
);

  instr_info_t info_d, info_e, info_m, info_w;
  logic [2:0]        tuse_rs, tuse_rt;
  logic              data_stall, md_stall;
  logic [DATA_W-1:0] wd_e, wd_m;
  logic [CNT_W-1:0]  count_d, count_q;
  logic              unused_info;

  instr_class #(.STAGE(STG_D)) u_cls_d (.ir(IR_D), .info(info_d));
  instr_class #(.STAGE(STG_E)) u_cls_e (.ir(IR_E), .info(info_e));
  instr_class #(.STAGE(STG_M)) u_cls_m (.ir(IR_M), .info(info_m));
  instr_class #(.STAGE(STG_W)) u_cls_w (.ir(IR_W), .info(info_w));

  assign unused_info = ^{info_d, info_e, info_m, info_w};

  // producer still needs time: it writes r and its result is later than the consumer's use
  function automatic logic late(input instr_info_t src, input logic [4:0] r, input logic [2:0] tuse);
    return src.we && (src.dst == r) && (tuse < {1'b0, src.tnew});
  endfunction

  // producer writes r and its result already exists in this stage
  function automatic logic ready(input instr_info_t src, input logic [4:0] r);
    return src.we && (src.dst == r) && (src.tnew == 2'd0);
  endfunction

  // how soon the instruction in D consumes rs and rt
  always_comb begin
    tuse_rs = 3'd4;
    tuse_rt = 3'd4;
    if (info_d.beq || info_d.jr || info_d.jalr)
      tuse_rs = 3'd0;
    else if (info_d.cal_r || info_d.cal_i || info_d.lw || info_d.sw || info_d.md_cal || info_d.md_mv)
      tuse_rs = 3'd1;
    if (info_d.beq)
      tuse_rt = 3'd0;
    else if (info_d.cal_r || info_d.md_cal)
      tuse_rt = 3'd1;
    else if (info_d.sw)
      tuse_rt = 3'd2;
  end

  // data hazards against E and M, plus MDU ops waiting for the unit to drain
  always_comb begin
    data_stall = late(info_e, info_d.rs, tuse_rs) || late(info_e, info_d.rt, tuse_rt) ||
                 late(info_m, info_d.rs, tuse_rs) || late(info_m, info_d.rt, tuse_rt);
    md_stall   = (info_d.md_cal || info_d.md_mv) && (md_busy || md_start);
    stall      = data_stall || md_stall;
    flush_E    = stall;
    md_start   = info_e.md_cal;
    md_op      = IR_E[1:0];
  end

  // forwarding muxes; nearer producers win
  always_comb begin
    wd_e = info_e.lui ? EXT_E : PC8_E;
    wd_m = (info_m.jal || info_m.jalr) ? PC8_M : AO_M;

    if (ready(info_e, info_d.rs))      RS_D = wd_e;
    else if (ready(info_m, info_d.rs)) RS_D = wd_m;
    else                               RS_D = RS_D_in;

    if (ready(info_e, info_d.rt))      RT_D = wd_e;
    else if (ready(info_m, info_d.rt)) RT_D = wd_m;
    else                               RT_D = RT_D_in;

    if (ready(info_m, info_e.rs))      RS_E = wd_m;
    else if (ready(info_w, info_e.rs)) RS_E = WD_W;
    else                               RS_E = RS_E_in;

    if (ready(info_m, info_e.rt))      RT_E = wd_m;
    else if (ready(info_w, info_e.rt)) RT_E = WD_W;
    else                               RT_E = RT_E_in;

    if (ready(info_w, info_m.rt))      RT_M = WD_W;
    else                               RT_M = RT_M_in;
  end

  // busy counter: load on start, otherwise count down to zero
  always_comb begin
    count_d = count_q;
    if (md_start)
      count_d = IR_E[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (count_q != '0)
      count_d = count_q - CNT_W'(1);
  end

  // busy counter register; reset clears it without waiting for a clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign md_busy = (count_q != '0);

endmodule
